wm8731_config: RTL and testbench
================================

WM8731_CONFIG -- requirements
Module: wm8731_config

Interface
REQ-001 Parameter CLK_DIV, default 125: clk cycles per quarter SCL period; 100 kHz SCL at 50 MHz; legal range 2..1023.
REQ-002 Parameter DEV_ADDR, default 7'h1A: codec 7-bit 2-wire device address, CSB low.
REQ-003 Port clk, input, 1: sole clock; all logic on posedge clk.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: level-sampled request to run the full configuration sequence.
REQ-006 Port sda_in, input, 1: sampled SDA line, externally synchronised.
REQ-007 Port scl, output, 1: push-pull SCL; codec never stretches clock.
REQ-008 Port sda_oe, output, 1: 1 = drive SDA low, 0 = release, pulled high externally.
REQ-009 Port busy, output, 1: high while a sequence is in progress.
REQ-010 Port done, output, 1: high after a sequence completes without error; held until next accepted start.
REQ-011 Port error, output, 1: high after a NACK abort; held until next accepted start.
REQ-012 Port cfg_index, output, 4: index of the table entry currently or last written.

Function
REQ-013 Fixed 11-entry table, written in order {reg, data9}: 0:{0x0F,0x000} reset; 1:{0x00,0x017}; 2:{0x01,0x017}; 3:{0x02,0x079}; 4:{0x03,0x079}; 5:{0x04,0x012}; 6:{0x05,0x000}; 7:{0x06,0x000}; 8:{0x07,0x042}; 9:{0x08,0x000}; 10:{0x09,0x001} active.
REQ-014 Each write is one transaction: START, byte0 = {DEV_ADDR,1'b0} = 0x34, byte1 = {reg[6:0],data[8]}, byte2 = data[7:0], STOP; bytes sent MSB first.
REQ-015 Quarter tick from a divider counting 0..CLK_DIV-1; divider runs only while busy and restarts at 0 on accepted start.
REQ-016 Data or ACK bit = 4 quarters: Q0 SCL low, SDA updated; Q1 and Q2 SCL high; Q3 SCL low; ACK sampled from sda_in on the last clk of Q2.
REQ-017 START = 4 quarters: SCL high and SDA released for Q0-Q1, SDA low from Q2, SCL low in Q3.
REQ-018 STOP = 4 quarters: SDA low and SCL low in Q0, SCL high from Q1, SDA released from Q2.
REQ-019 Each write ends with a 4-quarter GAP, lines released and SCL high.
REQ-020 One write = 4 + 3*36 + 4 + 4 = 120 quarters = 120*CLK_DIV clk cycles.
REQ-021 Control FSM states: IDLE, START, BIT, ACK, STOP, GAP, DONE, ERROR.
REQ-022 FSM transitions:
- IDLE/DONE/ERROR to START on start=1.
- START to BIT.
- BIT to ACK after bit 0.
- ACK with sda_in=0 to BIT if bytes remain, else STOP.
- ACK with sda_in=1 (NACK) to STOP with abort flag set.
- STOP to GAP.
- GAP to START with cfg_index+1 if cfg_index<10 and no abort.
- GAP to DONE after entry 10.
- GAP to ERROR if aborted.
REQ-023 Accepted start: done=0, error=0, cfg_index=0, busy=1 on the next clk edge.
REQ-024 start while busy is ignored; no restart or index change.
REQ-025 busy falls on the same edge that done or error rises.
REQ-026 NACK on any byte: no further bytes of that write; no later entries; cfg_index holds the failing entry.
REQ-027 start held high continuously after DONE/ERROR starts a new sequence; re-trigger is level-based.
REQ-028 sda_oe is only ever 0 or drive-low; SDA is never driven high.

Reset
REQ-029 On reset low, asynchronously: scl=1, sda_oe=0, busy=0, done=0, error=0, cfg_index=0, FSM=IDLE, divider=0.
REQ-030 Reset asserted mid-transaction releases both lines immediately; no STOP is generated.
REQ-031 After reset release, the block stays in IDLE until start=1 is sampled.

Verification
REQ-032 CLK_DIV=4, ACK-ing slave model, start pulsed 1 clk: busy=1 next edge; done=1, busy=0 after 11*480=5280 clks, ±2; error=0; cfg_index=10.
REQ-033 Same run with bus monitor: decode 11 transactions; entry 0 = 0x34,0x1E,0x00; entry 8 = 0x34,0x0E,0x42; entry 10 = 0x34,0x12,0x01.
REQ-034 Slave NACKs byte1 of entry 3: STOP follows that ACK slot; error=1, done=0, busy=0, cfg_index=3; no further START observed.
REQ-035 start re-pulsed at clk 1000 of a run: ignored; done still at 5280±2 clks from the first start.
REQ-036 reset low during byte2 of entry 5: same cycle scl=1, sda_oe=0, busy=0, cfg_index=0; after release and start, full sequence from entry 0.
REQ-037 Protocol checker, whole run: SDA changes only while SCL low, except at START/STOP; SCL high time = 2*CLK_DIV clks.

Source files
------------

// File: rtl/wm8731_config.sv
// WM8731 codec register loader: walks a fixed 11-entry table and writes each
// entry over the 2-wire bus as a 3-byte transaction (addr, reg/data[8], data[7:0]).
`timescale 1ns/1ps
module wm8731_config #(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] cfg_index
);

    localparam int               DIV_W      = 10;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]       LAST_ENTRY = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERROR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       qtr;
    logic [2:0]       bit_cnt;
    logic [1:0]       byte_cnt;
    logic             abort;
    logic             nack;
    logic             tick;
    logic             phase_end;
    logic [15:0]      entry;
    logic [7:0]       tx_byte;

    // Each table word is {reg[6:0], data[8:0]}.
    function automatic logic [15:0] entry_word(input logic [3:0] idx);
        case (idx)
            4'd0:    entry_word = {7'h0F, 9'h000};
            4'd1:    entry_word = {7'h00, 9'h017};
            4'd2:    entry_word = {7'h01, 9'h017};
            4'd3:    entry_word = {7'h02, 9'h079};
            4'd4:    entry_word = {7'h03, 9'h079};
            4'd5:    entry_word = {7'h04, 9'h012};
            4'd6:    entry_word = {7'h05, 9'h000};
            4'd7:    entry_word = {7'h06, 9'h000};
            4'd8:    entry_word = {7'h07, 9'h042};
            4'd9:    entry_word = {7'h08, 9'h000};
            default: entry_word = {7'h09, 9'h001};
        endcase
    endfunction

    assign entry     = entry_word(cfg_index);
    assign tick      = busy && (div_cnt == DIV_LAST);
    assign phase_end = tick && (qtr == 2'd3);

    always_comb begin
        case (byte_cnt)
            2'd0:    tx_byte = {DEV_ADDR, 1'b0};
            2'd1:    tx_byte = entry[15:8];
            default: tx_byte = entry[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_START;
            S_START: if (phase_end) state_next = S_BIT;
            S_BIT:   if (phase_end && bit_cnt == 3'd0) state_next = S_ACK;
            S_ACK: begin
                if (phase_end) begin
                    if (nack || byte_cnt == 2'd2) state_next = S_STOP;
                    else                          state_next = S_BIT;
                end
            end
            S_STOP: if (phase_end) state_next = S_GAP;
            S_GAP: begin
                if (phase_end) begin
                    if (abort)                          state_next = S_ERROR;
                    else if (cfg_index == LAST_ENTRY)   state_next = S_DONE;
                    else                                state_next = S_START;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Quarter timing, bit/byte position and entry index; bit_cnt wrapping
    // from 0 to 7 doubles as the reload for the following byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt   <= '0;
            qtr       <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            abort     <= 1'b0;
            nack      <= 1'b0;
            cfg_index <= '0;
        end else if (!busy) begin
            div_cnt <= '0;
            qtr     <= '0;
            if (start) begin
                cfg_index <= '0;
                abort     <= 1'b0;
                nack      <= 1'b0;
                bit_cnt   <= 3'd7;
                byte_cnt  <= 2'd0;
            end
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) qtr <= qtr + 2'd1;
            if (tick && qtr == 2'd2 && state == S_ACK) nack <= sda_in;
            if (phase_end) begin
                case (state)
                    S_START: begin
                        bit_cnt  <= 3'd7;
                        byte_cnt <= 2'd0;
                        nack     <= 1'b0;
                    end
                    S_BIT: bit_cnt <= bit_cnt - 3'd1;
                    S_ACK: begin
                        if (nack) abort    <= 1'b1;
                        else      byte_cnt <= byte_cnt + 2'd1;
                    end
                    S_GAP: begin
                        if (!abort && cfg_index != LAST_ENTRY) cfg_index <= cfg_index + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        error  = 1'b0;
        case (state)
            S_START: begin
                busy   = 1'b1;
                scl    = (qtr != 2'd3);
                sda_oe = qtr[1];
            end
            S_BIT: begin
                busy   = 1'b1;
                scl    = (qtr == 2'd1) || (qtr == 2'd2);
                sda_oe = !tx_byte[bit_cnt];
            end
            S_ACK: begin
                busy = 1'b1;
                scl  = (qtr == 2'd1) || (qtr == 2'd2);
            end
            S_STOP: begin
                busy   = 1'b1;
                scl    = (qtr != 2'd0);
                sda_oe = !qtr[1];
            end
            S_GAP:   busy  = 1'b1;
            S_DONE:  done  = 1'b1;
            S_ERROR: error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wm8731_config.sv
// Self-checking bench for wm8731_config: ACK/NACK slave, bus decoder and
// protocol checker, compared against a table/timing model of the sequence.
`timescale 1ns/1ps
module tb_wm8731_config;

    localparam int CLK_DIV     = 4;
    localparam int DEV_ADDR    = 'h1A;
    localparam int N_ENTRIES   = 11;
    localparam int WRITE_CLKS  = (4 + 3 * 36 + 4 + 4) * CLK_DIV;
    localparam int SEQ_CLKS    = N_ENTRIES * WRITE_CLKS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       sda_in;
    logic       scl;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] cfg_index;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    int nack_entry = -1;
    int nack_byte = -1;
    logic mon_clear = 1'b0;

    logic sda_line;
    logic slave_low = 1'b0;
    logic prev_scl = 1'b1;
    logic prev_sda = 1'b1;
    logic in_txn = 1'b0;
    logic skip_high = 1'b1;
    logic [7:0] shreg = '0;
    int bitn = 0;
    int high_len = 0;
    int mon_starts = 0;
    int mon_txn = 0;
    int mon_nb = 0;
    int prot_err = 0;
    int mon_bytes [48];
    int mon_len [16];

    int reg_tbl [11] = '{'h0F, 'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06, 'h07, 'h08, 'h09};
    int dat_tbl [11] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012, 'h000, 'h000, 'h042, 'h000, 'h001};

    wm8731_config #(
        .CLK_DIV  (CLK_DIV),
        .DEV_ADDR (7'h1A)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sda_in    (sda_in),
        .scl       (scl),
        .sda_oe    (sda_oe),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cfg_index (cfg_index)
    );

    assign sda_line = !(sda_oe || slave_low);
    assign sda_in   = sda_line;

    always #5 clk = !clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int model_byte(input int e, input int k);
        if (k == 0) return DEV_ADDR * 2;
        if (k == 1) return reg_tbl[e] * 2 + dat_tbl[e] / 256;
        return dat_tbl[e] % 256;
    endfunction

    // Bus decoder, ACK-ing slave and protocol checker, sampled mid clock.
    always @(negedge clk) begin
        if (!reset || mon_clear) begin
            prev_scl  <= scl;
            prev_sda  <= sda_line;
            in_txn    <= 1'b0;
            bitn      <= 0;
            slave_low <= 1'b0;
            skip_high <= 1'b1;
            high_len  <= 0;
            if (mon_clear) begin
                mon_starts <= 0;
                mon_txn    <= 0;
                mon_nb     <= 0;
                prot_err   <= 0;
                for (int i = 0; i < 16; i++) mon_len[i] <= 0;
            end
        end else begin
            prev_scl <= scl;
            prev_sda <= sda_line;
            if (scl) high_len <= high_len + 1;
            if (prev_scl && scl && prev_sda && !sda_line) begin
                if (in_txn) prot_err <= prot_err + 1;
                in_txn     <= 1'b1;
                bitn       <= 0;
                mon_nb     <= 0;
                mon_starts <= mon_starts + 1;
                skip_high  <= 1'b1;
            end else if (prev_scl && scl && !prev_sda && sda_line) begin
                if (!in_txn || bitn != 1) prot_err <= prot_err + 1;
                in_txn <= 1'b0;
                bitn   <= 0;
                if (mon_txn < 16) mon_len[mon_txn] <= mon_nb;
                mon_txn <= mon_txn + 1;
            end else if (!prev_scl && scl) begin
                high_len <= 1;
                if (bitn == 8) begin
                    bitn <= 0;
                end else begin
                    shreg <= {shreg[6:0], sda_line};
                    bitn  <= bitn + 1;
                    if (bitn == 7 && mon_txn < 16 && mon_nb < 3) begin
                        mon_bytes[mon_txn * 3 + mon_nb] <= {24'd0, shreg[6:0], sda_line};
                        mon_nb <= mon_nb + 1;
                    end
                end
            end else if (prev_scl && !scl) begin
                if (!skip_high && high_len != 2 * CLK_DIV) prot_err <= prot_err + 1;
                skip_high <= 1'b0;
                high_len  <= 0;
                if (bitn == 8)
                    slave_low <= !((mon_starts - 1 == nack_entry) && (mon_nb - 1 == nack_byte));
                else
                    slave_low <= 1'b0;
            end
        end
    end

    task automatic clear_monitor();
        @(negedge clk);
        mon_clear = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mon_clear = 1'b0;
    endtask

    task automatic launch(input int len, output int t0, output logic b, output logic d,
                          output logic e, output logic [3:0] idx);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        t0  = cyc;
        b   = busy;
        d   = done;
        e   = error;
        idx = cfg_index;
        for (int i = 1; i < len; i++) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int limit, output int t_end, output bit timed_out);
        int n = 0;
        timed_out = 1'b0;
        while (!(done || error)) begin
            @(negedge clk);
            n++;
            if (n > limit) begin
                timed_out = 1'b1;
                break;
            end
        end
        t_end = cyc;
    endtask

    task automatic test_reset();
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (scl !== 1'b1 || sda_oe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_lines: scl=%b sda_oe=%b, need 1/0", scl, sda_oe);
        end
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: busy/done/error=%b%b%b, need 000", busy, done, error);
        end
        tests_run++;
        if (cfg_index !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_index: cfg_index=%0d, need 0", cfg_index);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat ($urandom_range(5, 40)) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || scl !== 1'b1 || sda_oe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset: busy=%b scl=%b sda_oe=%b, need 0/1/0", busy, scl, sda_oe);
        end
    endtask

    task automatic test_full_sequence(input int len);
        int t0, t_end;
        bit to;
        logic b, d, e;
        logic [3:0] idx;
        nack_entry = -1;
        nack_byte  = -1;
        clear_monitor();
        repeat ($urandom_range(0, 30)) @(negedge clk);
        launch(len, t0, b, d, e, idx);
        tests_run++;
        if (b !== 1'b1 || d !== 1'b0 || e !== 1'b0 || idx !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL accept: busy/done/error=%b%b%b idx=%0d, need 100 idx 0", b, d, e, idx);
        end
        wait_end(SEQ_CLKS + 200, t_end, to);
        tests_run++;
        if (to || (t_end - t0) < SEQ_CLKS - 2 || (t_end - t0) > SEQ_CLKS + 2) begin
            tests_failed++;
            $display("[TB] FAIL seq_time: %0d clks (timeout=%0d), need %0d+-2", t_end - t0, to, SEQ_CLKS);
        end
        tests_run++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || cfg_index !== 4'd10) begin
            tests_failed++;
            $display("[TB] FAIL seq_end: done=%b error=%b busy=%b idx=%0d, need 1/0/0 idx 10",
                     done, error, busy, cfg_index);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (mon_starts !== N_ENTRIES || mon_txn !== N_ENTRIES) begin
            tests_failed++;
            $display("[TB] FAIL txn_count: starts=%0d stops=%0d, need %0d", mon_starts, mon_txn, N_ENTRIES);
        end
        for (int en = 0; en < N_ENTRIES; en++) begin
            tests_run++;
            if (mon_len[en] !== 3) begin
                tests_failed++;
                $display("[TB] FAIL txn_len[%0d]: %0d bytes, need 3", en, mon_len[en]);
            end
            for (int k = 0; k < 3; k++) begin
                tests_run++;
                if (mon_bytes[en * 3 + k] !== model_byte(en, k)) begin
                    tests_failed++;
                    $display("[TB] FAIL byte[%0d][%0d]: got 0x%02h, need 0x%02h",
                             en, k, mon_bytes[en * 3 + k], model_byte(en, k));
                end
            end
        end
        tests_run++;
        if (prot_err !== 0) begin
            tests_failed++;
            $display("[TB] FAIL protocol: %0d violations, need 0", prot_err);
        end
    endtask

    task automatic test_busy_restart();
        int t0, t_end, guard;
        bit to;
        logic b, d, e;
        logic [3:0] idx;
        launch($urandom_range(1, 5), t0, b, d, e, idx);
        guard = 0;
        while (cyc < t0 + 1000 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || cfg_index !== 4'((cyc - t0) / WRITE_CLKS)) begin
            tests_failed++;
            $display("[TB] FAIL restart_ignored: busy=%b idx=%0d, need 1 idx %0d",
                     busy, cfg_index, (cyc - t0) / WRITE_CLKS);
        end
        wait_end(SEQ_CLKS + 200, t_end, to);
        tests_run++;
        if (to || done !== 1'b1 || (t_end - t0) < SEQ_CLKS - 2 || (t_end - t0) > SEQ_CLKS + 2) begin
            tests_failed++;
            $display("[TB] FAIL restart_time: %0d clks done=%b, need %0d+-2 done 1", t_end - t0, done, SEQ_CLKS);
        end
    endtask

    task automatic test_level_retrigger();
        int t0, t_end;
        bit to;
        logic b, d, e;
        logic [3:0] idx;
        launch($urandom_range(2, 10), t0, b, d, e, idx);
        tests_run++;
        if (b !== 1'b1 || d !== 1'b0 || e !== 1'b0 || idx !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL level_retrigger: busy/done/error=%b%b%b idx=%0d, need 100 idx 0", b, d, e, idx);
        end
        wait_end(SEQ_CLKS + 200, t_end, to);
        tests_run++;
        if (to || done !== 1'b1 || (t_end - t0) < SEQ_CLKS - 2 || (t_end - t0) > SEQ_CLKS + 2) begin
            tests_failed++;
            $display("[TB] FAIL retrigger_time: %0d clks done=%b, need %0d+-2 done 1", t_end - t0, done, SEQ_CLKS);
        end
    endtask

    task automatic test_nack(input int en, input int bn);
        int t0, t_end, exp_t, starts_at_err;
        bit to;
        logic b, d, e;
        logic [3:0] idx;
        nack_entry = en;
        nack_byte  = bn;
        clear_monitor();
        launch(1, t0, b, d, e, idx);
        exp_t = en * WRITE_CLKS + (4 + (bn + 1) * 36 + 4 + 4) * CLK_DIV;
        wait_end(SEQ_CLKS + 200, t_end, to);
        tests_run++;
        if (to || (t_end - t0) < exp_t - 2 || (t_end - t0) > exp_t + 2) begin
            tests_failed++;
            $display("[TB] FAIL nack_time e%0d b%0d: %0d clks, need %0d+-2", en, bn, t_end - t0, exp_t);
        end
        tests_run++;
        if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || cfg_index !== 4'(en)) begin
            tests_failed++;
            $display("[TB] FAIL nack_end: error=%b done=%b busy=%b idx=%0d, need 1/0/0 idx %0d",
                     error, done, busy, cfg_index, en);
        end
        @(negedge clk);
        starts_at_err = mon_starts;
        tests_run++;
        if (starts_at_err !== en + 1 || mon_len[en] !== bn + 1) begin
            tests_failed++;
            $display("[TB] FAIL nack_bus: starts=%0d last_len=%0d, need %0d and %0d",
                     starts_at_err, mon_len[en], en + 1, bn + 1);
        end
        repeat (600) @(negedge clk);
        tests_run++;
        if (mon_starts !== starts_at_err || error !== 1'b1 || scl !== 1'b1 || sda_oe !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL nack_quiet: starts=%0d error=%b scl=%b sda_oe=%b, need %0d/1/1/0",
                     mon_starts, error, scl, sda_oe, starts_at_err);
        end
        tests_run++;
        if (prot_err !== 0) begin
            tests_failed++;
            $display("[TB] FAIL nack_protocol: %0d violations, need 0", prot_err);
        end
        nack_entry = -1;
        nack_byte  = -1;
    endtask

    task automatic test_reset_mid();
        int t0, t_end, guard, target;
        bit to;
        logic b, d, e;
        logic [3:0] idx;
        clear_monitor();
        launch(1, t0, b, d, e, idx);
        target = t0 + 5 * WRITE_CLKS + (4 + 2 * 36) * CLK_DIV + 15 * CLK_DIV;
        guard = 0;
        while (cyc < target && guard < SEQ_CLKS) begin
            @(negedge clk);
            guard++;
        end
        tests_run++;
        if (mon_starts !== 6 || mon_nb !== 2) begin
            tests_failed++;
            $display("[TB] FAIL mid_position: starts=%0d bytes=%0d, need 6 and 2", mon_starts, mon_nb);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (scl !== 1'b1 || sda_oe !== 1'b0 || busy !== 1'b0 || cfg_index !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset: scl=%b sda_oe=%b busy=%b idx=%0d, need 1/0/0 idx 0",
                     scl, sda_oe, busy, cfg_index);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat ($urandom_range(3, 20)) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_idle: busy=%b done=%b, need 0/0", busy, done);
        end
        clear_monitor();
        launch(1, t0, b, d, e, idx);
        wait_end(SEQ_CLKS + 200, t_end, to);
        repeat (5) @(negedge clk);
        tests_run++;
        if (to || done !== 1'b1 || (t_end - t0) < SEQ_CLKS - 2 || (t_end - t0) > SEQ_CLKS + 2 ||
            mon_txn !== N_ENTRIES) begin
            tests_failed++;
            $display("[TB] FAIL mid_rerun: %0d clks done=%b txns=%0d, need %0d+-2 done 1 txns %0d",
                     t_end - t0, done, mon_txn, SEQ_CLKS, N_ENTRIES);
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (mon_bytes[k] !== model_byte(0, k) || mon_bytes[30 + k] !== model_byte(10, k)) begin
                tests_failed++;
                $display("[TB] FAIL mid_bytes[%0d]: e0=0x%02h e10=0x%02h, need 0x%02h 0x%02h", k,
                         mon_bytes[k], mon_bytes[30 + k], model_byte(0, k), model_byte(10, k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence(1);
        test_busy_restart();
        test_level_retrigger();
        test_nack(3, 1);
        test_nack($urandom_range(0, 10), $urandom_range(0, 2));
        test_full_sequence($urandom_range(1, 50));
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
